// File: rtl/ball_ctrl.sv
// Bouncing-ball position controller: advances the ball centre once per frame tick,
// reflecting off the visible-area walls. Optional gravity mode: define BALL_GRAVITY_EN.
module ball_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int RADIUS   = 50,
  parameter int INIT_X   = 320,
  parameter int INIT_Y   = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic [3:0]  speed,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic        bounce,
  output logic        busy,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, UPD_X = 2'd2, UPD_Y = 2'd3} state_t;

  localparam logic [10:0] X_LIM = 11'(H_ACTIVE - 1 - RADIUS);
  localparam logic [10:0] Y_LIM = 11'(V_ACTIVE - 1 - RADIUS);
  localparam logic [10:0] R_LO  = 11'(RADIUS);

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;  // 1 = moving toward smaller coordinates
  logic [3:0]  spd_q, spd_d;
  logic        bx_q, bx_d;
  logic        bounce_q, bounce_d;
  logic signed [11:0] nx, ny;

`ifdef BALL_GRAVITY_EN
  logic signed [5:0] vy_q, vy_d, vy_inc;
`endif

  always_comb begin
    nx = dir_x_q ? $signed({1'b0, x_q}) - $signed({8'b0, spd_q})
                 : $signed({1'b0, x_q}) + $signed({8'b0, spd_q});
`ifdef BALL_GRAVITY_EN
    vy_inc = (vy_q >= 6'sd15) ? 6'sd15 : vy_q + 6'sd1;
    ny     = $signed({1'b0, y_q}) + {{6{vy_inc[5]}}, vy_inc};
`else
    ny = dir_y_q ? $signed({1'b0, y_q}) - $signed({8'b0, spd_q})
                 : $signed({1'b0, y_q}) + $signed({8'b0, spd_q});
`endif
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    spd_d    = spd_q;
    bx_d     = bx_q;
    bounce_d = 1'b0;
`ifdef BALL_GRAVITY_EN
    vy_d     = vy_q;
`endif
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (frame_tick && !pause) begin
          state_d = UPD_X;
          spd_d   = speed;
        end
      end
      UPD_X: begin
        state_d = UPD_Y;
        bx_d    = 1'b0;
        // A zero step leaves the ball where it is, even when it rests on a wall.
        if (spd_q != 4'd0) begin
          if (nx <= $signed({1'b0, R_LO})) begin
            x_d = R_LO; dir_x_d = 1'b0; bx_d = 1'b1;
          end else if (nx >= $signed({1'b0, X_LIM})) begin
            x_d = X_LIM; dir_x_d = 1'b1; bx_d = 1'b1;
          end else begin
            x_d = nx[10:0];
          end
        end
      end
      UPD_Y: begin
        state_d  = RUN;
        bounce_d = bx_q;
`ifdef BALL_GRAVITY_EN
        // Vertical motion follows the velocity register, independent of speed.
        vy_d = vy_inc;
        if (ny <= $signed({1'b0, R_LO})) begin
          y_d = R_LO; vy_d = 6'sd0; bounce_d = 1'b1;
        end else if (ny >= $signed({1'b0, Y_LIM})) begin
          y_d = Y_LIM; vy_d = -vy_inc; bounce_d = 1'b1;
        end else begin
          y_d = ny[10:0];
        end
`else
        if (spd_q != 4'd0) begin
          if (ny <= $signed({1'b0, R_LO})) begin
            y_d = R_LO; dir_y_d = 1'b0; bounce_d = 1'b1;
          end else if (ny >= $signed({1'b0, Y_LIM})) begin
            y_d = Y_LIM; dir_y_d = 1'b1; bounce_d = 1'b1;
          end else begin
            y_d = ny[10:0];
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= 11'(INIT_X);
      y_q      <= 11'(INIT_Y);
      dir_x_q  <= 1'b0;
      dir_y_q  <= 1'b0;
      spd_q    <= 4'd0;
      bx_q     <= 1'b0;
      bounce_q <= 1'b0;
`ifdef BALL_GRAVITY_EN
      vy_q     <= 6'sd0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      spd_q    <= spd_d;
      bx_q     <= bx_d;
      bounce_q <= bounce_d;
`ifdef BALL_GRAVITY_EN
      vy_q     <= vy_d;
`endif
    end
  end

  assign ball_x  = x_q;
  assign ball_y  = y_q;
  assign bounce  = bounce_q;
  assign busy    = (state_q == UPD_X) || (state_q == UPD_Y);
  assign state_o = state_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl: a behavioural model pushes expected positions into a
// queue per tick; a second instance with a square field exercises the corner bounce.
module tb_ball_ctrl;

  logic        clk = 1'b0;
  logic        reset, frame_tick, start, stop, pause;
  logic [3:0]  speed;
  logic [10:0] ball_x, ball_y;
  logic        bounce, busy;
  logic [1:0]  state_o;

  logic        c_tick, c_start;
  logic [3:0]  c_speed;
  logic [10:0] c_x, c_y;
  logic        c_bounce, c_busy;
  logic [1:0]  c_state;

  int total = 0;
  int bad   = 0;
  logic [22:0] exp_q[$];

  int   m_x, m_y, m_vy;
  logic m_dx, m_dy;
  logic last_b;

  always #5 clk = ~clk;

  ball_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .stop(stop),
    .pause(pause), .speed(speed), .ball_x(ball_x), .ball_y(ball_y), .bounce(bounce),
    .busy(busy), .state_o(state_o)
  );

  ball_ctrl #(.H_ACTIVE(640), .V_ACTIVE(640), .INIT_X(320), .INIT_Y(320)) u_corner (
    .clk(clk), .reset(reset), .frame_tick(c_tick), .start(c_start), .stop(1'b0),
    .pause(1'b0), .speed(c_speed), .ball_x(c_x), .ball_y(c_y), .bounce(c_bounce),
    .busy(c_busy), .state_o(c_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic axis(inout int p, inout logic d, input int s, input int lim, output logic hit);
    int n;
    hit = 1'b0;
    if (s == 0) return;
    n = d ? p - s : p + s;
    if (n <= 50) begin p = 50; d = 1'b0; hit = 1'b1; end
    else if (n >= lim) begin p = lim; d = 1'b1; hit = 1'b1; end
    else p = n;
  endtask

  task automatic model_step(input int s, output logic b);
    logic hx, hy;
    int n;
    axis(m_x, m_dx, s, 589, hx);
`ifdef BALL_GRAVITY_EN
    m_vy = (m_vy >= 15) ? 15 : m_vy + 1;
    n = m_y + m_vy;
    hy = 1'b0;
    if (n <= 50) begin m_y = 50; m_vy = 0; hy = 1'b1; end
    else if (n >= 429) begin m_y = 429; m_vy = -m_vy; hy = 1'b1; end
    else m_y = n;
`else
    n = 0;
    axis(m_y, m_dy, s, 429, hy);
`endif
    b = hx | hy;
  endtask

  task automatic model_reset();
    m_x = 320; m_y = 240; m_dx = 1'b0; m_dy = 1'b0; m_vy = 0;
  endtask

  task automatic do_tick(input int s);
    logic b;
    logic [22:0] e;
    model_step(s, b);
    exp_q.push_back({11'(m_x), 11'(m_y), b});
    @(negedge clk); frame_tick = 1'b1; speed = 4'(s);
    @(negedge clk); frame_tick = 1'b0;
    chk("busy_t1", busy, 1);
    @(negedge clk);
    e = exp_q[0];
    chk("busy_t2", busy, 1);
    chk("x_t2", ball_x, e[22:12]);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("busy_t3", busy, 0);
    chk("y_t3", ball_y, e[11:1]);
    chk("bounce_t3", bounce, e[0]);
    chk("state_run", state_o, 1);
    last_b = bounce;
  endtask

  task automatic c_step(input int s, output int nb);
    nb = 0;
    @(negedge clk); c_tick = 1'b1; c_speed = 4'(s);
    @(negedge clk); c_tick = 1'b0; if (c_bounce) nb++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); if (c_bounce) nb++;
    end
  endtask

  initial begin
    int nb;
    reset = 1'b1; frame_tick = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; speed = 4'd0;
    c_tick = 1'b0; c_start = 1'b0; c_speed = 4'd0; last_b = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_x", ball_x, 320);
    chk("rst_y", ball_y, 240);
    chk("rst_busy", busy, 0);
    chk("rst_bounce", bounce, 0);
    chk("rst_state", state_o, 0);

    // Ticks and stop are ignored while idle.
    frame_tick = 1'b1; stop = 1'b1; speed = 4'd9;
    @(negedge clk); frame_tick = 1'b0; stop = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_state", state_o, 0);

    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_state", state_o, 1);

`ifdef BALL_GRAVITY_EN
    for (int i = 0; i < 10; i++) do_tick(4);
    chk("grav_y", ball_y, 295);
    chk("grav_x", ball_x, 360);
`else
    do_tick(4);
    chk("first_x", ball_x, 324);
    chk("first_y", ball_y, 244);
    chk("first_bounce", last_b, 0);

    for (int i = 0; i < 17; i++) do_tick(15);
    do_tick(8);
    chk("pre_wall_x", ball_x, 587);
    do_tick(5);
    chk("wall_x", ball_x, 589);
    chk("wall_bounce", last_b, 1);
    do_tick(5);
    chk("after_wall_x", ball_x, 584);

    do_tick(0);
    chk("spd0_bounce", last_b, 0);

    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); frame_tick = 1'b1; speed = 4'd7;
      @(negedge clk); frame_tick = 1'b0;
      chk("pause_busy", busy, 0);
      @(negedge clk);
      chk("pause_busy2", busy, 0);
      chk("pause_x", ball_x, m_x);
      chk("pause_y", ball_y, m_y);
    end
    pause = 1'b0;

    @(negedge clk); stop = 1'b1; frame_tick = 1'b1; speed = 4'd7;
    @(negedge clk); stop = 1'b0; frame_tick = 1'b0;
    chk("stop_state", state_o, 0);
    chk("stop_busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("stop_x", ball_x, m_x);
    chk("stop_y", ball_y, m_y);

    start = 1'b1;
    @(negedge clk); start = 1'b0; frame_tick = 1'b1; speed = 4'd7;
    @(negedge clk); frame_tick = 1'b0;
    chk("updx_state", state_o, 2);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    chk("midrst_state", state_o, 0);
    chk("midrst_x", ball_x, 320);
    chk("midrst_y", ball_y, 240);
    chk("midrst_busy", busy, 0);

    // Square field keeps x == y, so the ball reaches the corner diagonally.
    c_start = 1'b1;
    @(negedge clk); c_start = 1'b0;
    for (int i = 0; i < 17; i++) c_step(15, nb);
    c_step(14, nb);
    chk("c_top_x", c_x, 589);
    chk("c_top_y", c_y, 589);
    chk("c_top_bounces", nb, 1);
    for (int i = 0; i < 35; i++) c_step(15, nb);
    c_step(13, nb);
    chk("c_pre_x", c_x, 51);
    chk("c_pre_y", c_y, 51);
    c_step(3, nb);
    chk("c_corner_x", c_x, 50);
    chk("c_corner_y", c_y, 50);
    chk("c_corner_bounces", nb, 1);
    c_step(3, nb);
    chk("c_away_x", c_x, 53);
    chk("c_away_y", c_y, 53);
    chk("c_away_bounces", nb, 0);
`endif

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
